// File: rtl/eth_rx_frame_ctrl.sv
// eth_rx_frame_ctrl: assembles RMII dibits into bytes, strips FCS, writes payload to a circular RAM and commits or rewinds each frame
module eth_rx_frame_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            in_dibit,
  input  logic                  in_clk,
  input  logic                  in_done,
  input  logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  output logic [10:0]           desc_len,
  output logic [CNT_WIDTH-1:0]  cnt_ok,
  output logic [CNT_WIDTH-1:0]  cnt_crc_err,
  output logic [CNT_WIDTH-1:0]  cnt_drop
);
  typedef enum logic [1:0] {IDLE, RECV, DROP, CHECK} state_t;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  state_t state_q, state_d;
  logic [31:0] crc_q, crc_d, base_crc;
  logic [1:0] dcnt_q, dcnt_d, base_dcnt;
  logic [5:0] part_q, part_d;
  logic [7:0] nbyte;
  logic [3:0][7:0] dl_q, dl_d;
  logic [10:0] len_q, len_d, base_len;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, start_q, start_d, nxt_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, desc_addr_q, desc_addr_d;
  logic wr_en_q, wr_en_d, desc_valid_q, desc_valid_d, take, good, pending;
  logic [7:0] wr_data_q, wr_data_d;
  logic [10:0] desc_len_q, desc_len_d;
  logic [CNT_WIDTH-1:0] ok_q, ok_d, err_q, err_d, drop_q, drop_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // next-state, byte assembly, CRC, RAM writes and frame commit/rewind
  always_comb begin
    state_d = state_q;
    base_crc = (state_q == RECV) ? crc_q : 32'hFFFFFFFF;
    base_len = (state_q == RECV) ? len_q : 11'd0;
    base_dcnt = (state_q == RECV) ? dcnt_q : 2'd0;
    crc_d = base_crc;
    len_d = base_len;
    dcnt_d = base_dcnt;
    part_d = part_q;
    dl_d = dl_q;
    nbyte = {in_dibit, part_q};
    nxt_ptr = wr_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    start_d = start_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pending = desc_valid_q && !desc_ready;
    desc_valid_d = pending;
    desc_addr_d = desc_addr_q;
    desc_len_d = desc_len_q;
    ok_d = ok_q;
    err_d = err_q;
    drop_d = drop_q;
    take = in_clk && (state_q == IDLE || state_q == RECV);
    good = (crc_q == 32'hDEBB20E3) && len_q >= MIN_L && len_q <= MAX_L && dcnt_q == 2'd0;
    if (state_q == IDLE && in_clk) begin
      state_d = RECV;
      start_d = commit_q;
    end
    if (take) begin
      crc_d = crc_step(base_crc, in_dibit);
      dcnt_d = base_dcnt + 1'b1;
      part_d = nbyte[7:2];
      if (base_dcnt == 2'd3) begin
        len_d = base_len + 1'b1;
        dl_d = {dl_q[2:0], nbyte};
        if (base_len >= MAX_L) state_d = DROP;
        else if (base_len >= 11'd4) begin
          if (nxt_ptr == rd_ptr) state_d = DROP;
          else begin
            wr_en_d = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = dl_q[3];
            wr_ptr_d = nxt_ptr;
          end
        end
      end
    end
    if (state_q == RECV && in_done) state_d = CHECK;
    if (state_q == DROP && in_done) begin
      wr_ptr_d = commit_q;
      drop_d = sat_inc(drop_q);
      state_d = IDLE;
    end
    if (state_q == CHECK) begin
      state_d = IDLE;
      if (good && !pending) begin
        commit_d = wr_ptr_q;
        desc_addr_d = start_q;
        desc_len_d = len_q - 11'd4;
        desc_valid_d = 1'b1;
        ok_d = sat_inc(ok_q);
      end else begin
        wr_ptr_d = commit_q;
        drop_d = good ? sat_inc(drop_q) : drop_q;
        err_d = good ? err_q : sat_inc(err_q);
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q <= 32'hFFFFFFFF;
      dcnt_q <= '0;
      part_q <= '0;
      dl_q <= '0;
      len_q <= '0;
      wr_ptr_q <= '0;
      commit_q <= '0;
      start_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      desc_valid_q <= 1'b0;
      desc_addr_q <= '0;
      desc_len_q <= '0;
      ok_q <= '0;
      err_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      dcnt_q <= dcnt_d;
      part_q <= part_d;
      dl_q <= dl_d;
      len_q <= len_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      start_q <= start_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      desc_valid_q <= desc_valid_d;
      desc_addr_q <= desc_addr_d;
      desc_len_q <= desc_len_d;
      ok_q <= ok_d;
      err_q <= err_d;
      drop_q <= drop_d;
    end
  end

  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign desc_valid = desc_valid_q;
  assign desc_addr = desc_addr_q;
  assign desc_len = desc_len_q;
  assign cnt_ok = ok_q;
  assign cnt_crc_err = err_q;
  assign cnt_drop = drop_q;
endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// tb_eth_rx_frame_ctrl: scoreboard bench driving directed frames into a 4 KiB and a 64-byte instance
module tb_eth_rx_frame_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] in_dibit = 2'd0;
  logic in_clk_a = 1'b0, in_clk_b = 1'b0, in_done = 1'b0, desc_ready = 1'b1, desc_ready_b = 1'b1;
  logic [11:0] rd_ptr_a = '0;
  logic [5:0] rd_ptr_b = '0;
  logic wr_en_a, desc_valid_a, wr_en_b, desc_valid_b;
  logic [11:0] wr_addr_a, desc_addr_a;
  logic [5:0] wr_addr_b, desc_addr_b;
  logic [7:0] wr_data_a, wr_data_b, cnt_ok_a, cnt_err_a, cnt_drop_a, cnt_ok_b, cnt_err_b, cnt_drop_b;
  logic [10:0] desc_len_a, desc_len_b;
  logic [19:0] wq_a[$], wq_b[$];
  logic [22:0] dq_a[$], dq_b[$];
  logic [7:0] frm[$];
  int n_cmp = 0, n_bad = 0, ptr = 0, e_ok = 0, e_err = 0, e_drop = 0;

  always #5 clk = ~clk;

  eth_rx_frame_ctrl dut_a (
    .clk(clk), .reset(reset), .in_dibit(in_dibit), .in_clk(in_clk_a), .in_done(in_done),
    .rd_ptr(rd_ptr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .desc_valid(desc_valid_a), .desc_ready(desc_ready), .desc_addr(desc_addr_a), .desc_len(desc_len_a),
    .cnt_ok(cnt_ok_a), .cnt_crc_err(cnt_err_a), .cnt_drop(cnt_drop_a)
  );

  eth_rx_frame_ctrl #(.ADDR_WIDTH(6)) dut_b (
    .clk(clk), .reset(reset), .in_dibit(in_dibit), .in_clk(in_clk_b), .in_done(in_done),
    .rd_ptr(rd_ptr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .desc_valid(desc_valid_b), .desc_ready(desc_ready_b), .desc_addr(desc_addr_b), .desc_len(desc_len_b),
    .cnt_ok(cnt_ok_b), .cnt_crc_err(cnt_err_b), .cnt_drop(cnt_drop_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // write and descriptor scoreboards, popped whenever a DUT presents output
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en_a) begin
        if (wq_a.size() == 0) chk("unexpected_wr_a", {wr_addr_a, wr_data_a}, 32'hFFFFFFFF);
        else chk("wr_a", {wr_addr_a, wr_data_a}, wq_a.pop_front());
      end
      if (wr_en_b) begin
        if (wq_b.size() == 0) chk("unexpected_wr_b", {wr_addr_b, wr_data_b}, 32'hFFFFFFFF);
        else chk("wr_b", {6'd0, wr_addr_b, wr_data_b}, wq_b.pop_front());
      end
      if (desc_valid_a && desc_ready) begin
        if (dq_a.size() == 0) chk("unexpected_desc_a", {desc_addr_a, desc_len_a}, 32'hFFFFFFFF);
        else chk("desc_a", {desc_addr_a, desc_len_a}, dq_a.pop_front());
      end
      if (desc_valid_b && desc_ready_b) begin
        if (dq_b.size() == 0) chk("unexpected_desc_b", {desc_addr_b, desc_len_b}, 32'hFFFFFFFF);
        else chk("desc_b", {6'd0, desc_addr_b, desc_len_b}, dq_b.pop_front());
      end
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = r[0] ^ b[k] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  task automatic build(input int n_pay, input int seed);
    logic [31:0] c;
    logic [7:0] b;
    c = 32'hFFFFFFFF;
    frm.delete();
    for (int i = 0; i < n_pay; i++) begin
      b = 8'((i * 7 + seed * 13) & 255);
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
  endtask

  task automatic push_wr(input int n, input int base);
    for (int i = 0; i < n; i++) wq_a.push_back({12'(base + i), frm[i]});
  endtask

  task automatic dib(input bit sel, input logic [1:0] d);
    @(posedge clk); #1;
    in_dibit = d;
    if (sel) in_clk_b = 1'b1; else in_clk_a = 1'b1;
    @(posedge clk); #1;
    in_clk_a = 1'b0;
    in_clk_b = 1'b0;
  endtask

  task automatic send(input bit sel, input int nb, input bit extra, input bit fin);
    logic [7:0] b;
    for (int i = 0; i < nb; i++) begin
      b = frm[i];
      for (int j = 0; j < 4; j++) dib(sel, b[2*j +: 2]);
    end
    if (extra) dib(sel, 2'b01);
    if (fin) begin
      @(posedge clk); #1 in_done = 1'b1;
      @(posedge clk); #1 in_done = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_cnt();
    chk("cnt_ok", cnt_ok_a, e_ok);
    chk("cnt_crc_err", cnt_err_a, e_err);
    chk("cnt_drop", cnt_drop_a, e_drop);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_desc_valid", desc_valid_a, 0);
    chk("rst_desc_addr", desc_addr_a, 0);
    chk("rst_desc_len", desc_len_a, 0);
    e_ok = 0; e_err = 0; e_drop = 0; ptr = 0;
    chk_cnt();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    build(60, 1); push_wr(60, ptr); dq_a.push_back({12'(ptr), 11'd60});
    send(0, frm.size(), 0, 1); ptr += 60; e_ok++; chk_cnt();
    do_reset();
    build(60, 2); frm[10] = frm[10] ^ 8'h01; push_wr(60, ptr);
    send(0, frm.size(), 0, 1); e_err++; chk_cnt();
    build(60, 3); push_wr(60, ptr); dq_a.push_back({12'(ptr), 11'd60});
    send(0, frm.size(), 0, 1); ptr += 60; e_ok++; chk_cnt();
    build(36, 4); push_wr(36, ptr);
    send(0, frm.size(), 0, 1); e_err++; chk_cnt();
    build(60, 5); push_wr(60, ptr);
    send(0, frm.size(), 1, 1); e_err++; chk_cnt();
    desc_ready = 1'b0;
    build(60, 6); push_wr(60, ptr); dq_a.push_back({12'(ptr), 11'd60});
    send(0, frm.size(), 0, 1); e_ok++; chk_cnt();
    chk("hold_valid1", desc_valid_a, 1);
    chk("hold_desc1", {desc_addr_a, desc_len_a}, {12'(ptr), 11'd60});
    build(60, 7); push_wr(60, ptr + 60);
    send(0, frm.size(), 0, 1); e_drop++; chk_cnt();
    chk("hold_valid2", desc_valid_a, 1);
    chk("hold_desc2", {desc_addr_a, desc_len_a}, {12'(ptr), 11'd60});
    ptr += 60;
    desc_ready = 1'b1;
    @(posedge clk); #1;
    chk("desc_cleared", desc_valid_a, 0);
    build(60, 8); push_wr(60, ptr); dq_a.push_back({12'(ptr), 11'd60});
    send(0, frm.size(), 0, 1); ptr += 60; e_ok++; chk_cnt();
    build(96, 9);
    for (int i = 0; i < 63; i++) wq_b.push_back({6'd0, 6'(i), frm[i]});
    send(1, frm.size(), 0, 1);
    chk("b_cnt_drop", cnt_drop_b, 1);
    chk("b_cnt_ok0", cnt_ok_b, 0);
    build(60, 10);
    for (int i = 0; i < 60; i++) wq_b.push_back({6'd0, 6'(i), frm[i]});
    dq_b.push_back({6'd0, 6'd0, 11'd60});
    send(1, frm.size(), 0, 1);
    chk("b_cnt_ok1", cnt_ok_b, 1);
    chk("b_cnt_err", cnt_err_b, 0);
    build(60, 11); push_wr(26, ptr);
    send(0, 30, 0, 0);
    do_reset();
    build(60, 12); push_wr(60, ptr); dq_a.push_back({12'(ptr), 11'd60});
    send(0, frm.size(), 0, 1); ptr += 60; e_ok++; chk_cnt();
    chk("wq_a_left", wq_a.size(), 0);
    chk("wq_b_left", wq_b.size(), 0);
    chk("dq_a_left", dq_a.size(), 0);
    chk("dq_b_left", dq_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Receive-side frame controller behind the RMII PHY driver. It consumes the dibit stream (dibit, strobe, done pulse) and assembles bytes, LSB dibit first. It runs an internal crc32 instance over every dibit, strips the 4-byte FCS and writes payload bytes into an external circular byte RAM. When a frame ends it either commits the frame and publishes a descriptor to the consumer (valid/ready), or rewinds the write pointer and counts the error.

Parameters:
ADDR_WIDTH, 12, byte-address width of the external frame RAM (2^ADDR_WIDTH bytes).
MIN_LEN, 64, minimum frame length in bytes, FCS included.
MAX_LEN, 1518, maximum frame length in bytes, FCS included.
CNT_WIDTH, 8, width of the saturating statistics counters.

Ports:
clk  in  1  RMII reference clock domain.
reset  in  1  synchronous, active-high.
in_dibit  in  2  received dibit, valid when in_clk=1.
in_clk  in  1  dibit strobe, one cycle per dibit.
in_done  in  1  end-of-frame pulse; never coincident with in_clk.
rd_ptr  in  ADDR_WIDTH  consumer read pointer; bytes below it are free.
wr_en  out  1  RAM write strobe.
wr_addr  out  ADDR_WIDTH  RAM write address.
wr_data  out  8  RAM write data.
desc_valid  out  1  committed-frame descriptor valid.
desc_ready  in  1  consumer accepts the descriptor.
desc_addr  out  ADDR_WIDTH  start address of the frame.
desc_len  out  11  payload length in bytes, FCS excluded.
cnt_ok  out  CNT_WIDTH  frames committed.
cnt_crc_err  out  CNT_WIDTH  frames rejected for CRC, length or misalignment.
cnt_drop  out  CNT_WIDTH  frames dropped for overflow, oversize or pending descriptor.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, desc_valid=0, desc_addr=0, desc_len=0, all counters=0. Internal pointers wr_ptr=commit_ptr=0. State=IDLE. Reset mid-frame abandons the frame with no counter update.
- CRC: internal crc32 is held in reset while in IDLE or CHECK and is clocked by in_clk. A frame is good iff crc out == 32'h2144DF1C, i.e. register residue 32'hDEBB20E3.
- Byte assembly: a 2-bit dibit counter. Dibit j of a byte goes to bits [2j+1:2j]. Byte count len increments when the 4th dibit lands. Assembled bytes enter a 4-deep byte delay line.
- Write timing: on the in_clk that completes byte k with k>=4, the next cycle gives wr_en=1, wr_data=byte k-4, wr_addr=wr_ptr, then wr_ptr increments (wraps mod 2^ADDR_WIDTH). The last 4 bytes (FCS) are never written. wr_en is otherwise 0.
- States:
  - IDLE: first in_clk goes to RECV; frame start = commit_ptr; the dibit is processed. in_done in IDLE is ignored.
  - RECV: on in_done go to CHECK. If a write would make wr_ptr+1 == rd_ptr (full), go to DROP with no write. If len would exceed MAX_LEN, go to DROP.
  - DROP: ignore dibits; on in_done, wr_ptr <= commit_ptr, cnt_drop++, go to IDLE.
  - CHECK (one cycle): good = crc ok && MIN_LEN <= len <= MAX_LEN && dibit counter == 0.
    - good && !desc_valid: commit_ptr <= wr_ptr, desc_addr=frame start, desc_len=len-4, desc_valid=1, cnt_ok++.
    - good && desc_valid (still pending): rewind, cnt_drop++.
    - !good: rewind, cnt_crc_err++.
    - Then go to IDLE.
- Descriptor handshake: desc_valid stays high, with desc_addr/desc_len stable, until a cycle where desc_valid && desc_ready, then it clears next cycle. A commit in the same cycle as acceptance is permitted and loads the new descriptor, so desc_valid stays 1.
- Counters saturate at all-ones.
- Free space is computed as (rd_ptr - wr_ptr - 1) mod 2^ADDR_WIDTH. One slot is always kept empty.

Test Plan:
- Good 64-byte frame (60 payload + correct FCS), desc_ready=1: exactly 60 wr_en pulses at addr 0..59 carrying the payload; desc_valid with desc_addr=0, desc_len=60; cnt_ok=1.
- Same frame with one payload bit flipped: 60 writes occur; then wr_ptr returns to 0, no desc_valid, cnt_crc_err=1. The next good frame is also written at addr 0.
- 40-byte runt with valid FCS, and a frame with one extra trailing dibit: both give cnt_crc_err++ and no descriptor.
- desc_ready=0, two good frames back to back: first descriptor held stable; second gives cnt_drop=1 and commit_ptr unchanged. Asserting desc_ready then clears desc_valid.
- ADDR_WIDTH=6, rd_ptr=0, 100-byte good frame: writes stop at addr 62; then DROP, cnt_drop=1, wr_ptr=0 after in_done.
- reset asserted mid-RECV at byte 30: all outputs and counters zero next cycle. A following good frame commits at addr 0.
